// File: rtl/rca_behavioural.sv
// Registered WIDTH-bit ripple-carry adder with carry-in, carry-out and signed overflow.
// Latency: one clock from an in_valid edge to s/cout/ovf/out_valid.
// No backpressure: a new operand set is accepted on every in_valid cycle.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      synchronous active-low reset; clears every output and wins over in_valid
//   in_valid   a/b/cin are meaningful this cycle; capture their sum on this edge
//   a, b       WIDTH-bit operands (unsigned; also read as two's complement for ovf)
//   cin        carry into bit 0
//   s          registered low WIDTH bits of a+b+cin
//   cout       registered carry out of the MSB
//   ovf        registered two's-complement overflow (carry into MSB ^ carry out of MSB)
//   out_valid  s/cout/ovf were captured on the previous edge
module rca_behavioural #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid
);

    // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_comb;
    logic             ovf_comb;

    assign c[0] = cin;

    // One full adder per bit; the carry ripples through the whole chain
    // with no lookahead, so the critical path is WIDTH carry stages.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic p;
        assign p           = a[i] ^ b[i];
        assign sum_comb[i] = p ^ c[i];
        assign c[i+1]      = (a[i] & b[i]) | (c[i] & p);
    end

    // Signed overflow: the MSB received a carry it did not pass on, or
    // passed on a carry it did not receive.
    assign ovf_comb = c[WIDTH] ^ c[WIDTH-1];

    // Result registers only load on in_valid, so unknown operands on idle
    // cycles never reach the held outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s    <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (in_valid) begin
            s    <= sum_comb;
            cout <= c[WIDTH];
            ovf  <= ovf_comb;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_rca_behavioural.sv
module tb_rca_behavioural;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;

    logic [3:0]  a4, b4, s4;
    logic        cin4, cout4, ovf4, ov4;

    logic [0:0]  a1, b1, s1;
    logic        cin1, cout1, ovf1, ov1;

    logic [15:0] a16, b16, s16;
    logic        cin16, cout16, ovf16, ov16;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rca_behavioural #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a4), .b(b4), .cin(cin4),
        .s(s4), .cout(cout4), .ovf(ovf4), .out_valid(ov4)
    );

    rca_behavioural #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a1), .b(b1), .cin(cin1),
        .s(s1), .cout(cout1), .ovf(ovf1), .out_valid(ov1)
    );

    rca_behavioural #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a16), .b(b16), .cin(cin16),
        .s(s16), .cout(cout16), .ovf(ovf16), .out_valid(ov16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check4(input string tag, input logic [3:0] es, input logic ec,
                          input logic eo, input logic ev);
        check({tag, ".s"},         {28'd0, s4}, {28'd0, es});
        check({tag, ".cout"},      {31'd0, cout4}, {31'd0, ec});
        check({tag, ".ovf"},       {31'd0, ovf4}, {31'd0, eo});
        check({tag, ".out_valid"}, {31'd0, ov4}, {31'd0, ev});
    endtask

    task automatic drive4(input logic [3:0] va, input logic [3:0] vb, input logic vc);
        a4 = va; b4 = vb; cin4 = vc;
    endtask

    // Independent reference: overflow when both operands share a sign and
    // the result's sign differs.
    function automatic logic ref_ovf(input logic sa, input logic sb, input logic ss);
        return (sa == sb) && (ss != sa);
    endfunction

    logic [16:0] full16;
    logic [4:0]  full4;
    logic [1:0]  full1;
    logic [15:0] va16 [6];
    logic [15:0] vb16 [6];
    logic        vc16 [6];

    initial begin
        rst_n = 1'b0; in_valid = 1'b1;
        drive4(4'd5, 4'd5, 1'b1);
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        a16 = 16'hffff; b16 = 16'h1; cin16 = 1'b0;

        // 1: reset dominates in_valid, then idle stays at zero
        step();
        check4("rst", 4'h0, 1'b0, 1'b0, 1'b0);
        check("rst16.s", {16'd0, s16}, 32'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        step();
        check4("idle0", 4'h0, 1'b0, 1'b0, 1'b0);

        // 2: 6+4 = 10, positive+positive gives negative -> overflow
        in_valid = 1'b1; drive4(4'b0110, 4'b0100, 1'b0);
        step();
        check4("t2", 4'b1010, 1'b0, 1'b1, 1'b1);

        // 3: back-to-back results on consecutive edges
        drive4(4'b0010, 4'b0001, 1'b0); step(); check4("t3a", 4'b0011, 1'b0, 1'b0, 1'b1);
        drive4(4'b0001, 4'b0011, 1'b0); step(); check4("t3b", 4'b0100, 1'b0, 1'b0, 1'b1);
        drive4(4'b0111, 4'b0111, 1'b0); step(); check4("t3c", 4'b1110, 1'b0, 1'b1, 1'b1);

        // 4: wrap-around boundaries
        drive4(4'b1111, 4'b1111, 1'b1); step(); check4("t4max", 4'b1111, 1'b1, 1'b0, 1'b1);
        drive4(4'b1000, 4'b1000, 1'b0); step(); check4("t4min", 4'b0000, 1'b1, 1'b1, 1'b1);

        // 5: hold with in_valid low, then reset with in_valid high
        drive4(4'b0011, 4'b0001, 1'b0); step(); check4("t5load", 4'b0100, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive4(4'($urandom), 4'($urandom), 1'($urandom));
            step();
            check4("t5hold", 4'b0100, 1'b0, 1'b0, 1'b0);
        end
        rst_n = 1'b0; in_valid = 1'b1; drive4(4'b1111, 4'b1111, 1'b1);
        step();
        check4("t5rst", 4'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // 6a: exhaustive WIDTH=4 (and WIDTH=1 riding along)
        for (int i = 0; i < 512; i++) begin
            logic [8:0] iv;
            iv = 9'(i);
            drive4(iv[3:0], iv[7:4], iv[8]);
            a1 = iv[0]; b1 = iv[1]; cin1 = iv[2];
            step();
            full4 = {1'b0, iv[3:0]} + {1'b0, iv[7:4]} + {4'd0, iv[8]};
            full1 = {1'b0, iv[0]} + {1'b0, iv[1]} + {1'b0, iv[2]};
            check("ex4.sum", {27'd0, cout4, s4}, {27'd0, full4});
            check("ex4.ovf", {31'd0, ovf4}, {31'd0, ref_ovf(iv[3], iv[7], full4[3])});
            check("ex4.vld", {31'd0, ov4}, 32'd1);
            check("ex1.sum", {30'd0, cout1, s1}, {30'd0, full1});
            check("ex1.ovf", {31'd0, ovf1}, {31'd0, ref_ovf(iv[0], iv[1], full1[0])});
        end

        // 6b: WIDTH=16 directed spot checks
        va16[0] = 16'hffff; vb16[0] = 16'hffff; vc16[0] = 1'b1; // 1_ffff, no ovf
        va16[1] = 16'h8000; vb16[1] = 16'h8000; vc16[1] = 1'b0; // 1_0000, ovf
        va16[2] = 16'h7fff; vb16[2] = 16'h0001; vc16[2] = 1'b0; // 0_8000, ovf
        va16[3] = 16'h1234; vb16[3] = 16'h4321; vc16[3] = 1'b1; // 0_5556
        va16[4] = 16'h0000; vb16[4] = 16'h0000; vc16[4] = 1'b0; // 0
        va16[5] = 16'hffff; vb16[5] = 16'h0000; vc16[5] = 1'b1; // 1_0000, no ovf
        for (int j = 0; j < 6; j++) begin
            a16 = va16[j]; b16 = vb16[j]; cin16 = vc16[j];
            step();
            full16 = {1'b0, va16[j]} + {1'b0, vb16[j]} + {16'd0, vc16[j]};
            check("w16.sum", {15'd0, cout16, s16}, {15'd0, full16});
            check("w16.ovf", {31'd0, ovf16},
                  {31'd0, ref_ovf(va16[j][15], vb16[j][15], full16[15])});
            check("w16.vld", {31'd0, ov16}, 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
